pim_instr_arbiter: RTL and testbench

- Shares the single 64-bit PIM instruction AXI-Stream input of the PIM controller among NUM_REQ instruction sources, for example host DMA, a local sequencer and a debug port.
- Arbitration is round-robin with group locking. A granted source keeps the stream until it marks the end of its instruction group or hits BURST_MAX beats. This keeps multi-instruction PIM sequences contiguous.
- The block sits directly upstream of the controller's instruction slave port.
- It holds a one-entry registered output stage, so the controller sees clean, registered valid and data.

---
 rtl/pim_pkg.sv | 28 ++
 rtl/rr_arbiter_comb.sv | 17 +
 rtl/pim_instr_arbiter.sv | 107 ++++++++++
 tb/tb_pim_instr_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_pkg.sv
// Shared PIM definitions: instruction width, arbiter state encoding and the
// round-robin winner search reused by the instruction and command arbiters.
package pim_pkg;

    localparam int unsigned PIM_INSTR_W = 64;

    localparam logic StIdle = 1'b0;
    localparam logic StLock = 1'b1;

    // First set bit of valid at or above ptr, wrapping modulo n (n <= 16).
    function automatic int unsigned rr_pick(input logic [15:0] valid, input int unsigned ptr,
                                            input int unsigned n);
        int unsigned win;
        int unsigned idx;
        logic found;
        win = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            idx = (ptr + i) % n;
            if (!found && i < n && valid[idx[3:0]]) begin
                win = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter_comb.sv
// Purely combinational round-robin winner selection starting at ptr.
module rr_arbiter_comb
    import pim_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    assign winner = ID_W'(rr_pick(16'(valid), 32'(ptr), NUM_REQ));
    assign any    = |valid;

endmodule

// File: rtl/pim_instr_arbiter.sv
// Round-robin, group-locking arbiter feeding the PIM controller instruction
// stream through a one-entry registered output stage.
module pim_instr_arbiter
    import pim_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned INSTR_W   = PIM_INSTR_W,
    parameter int unsigned BURST_MAX = 8,
    parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_REQ*INSTR_W-1:0] s_instr,
    input  logic [NUM_REQ-1:0]         s_valid,
    input  logic [NUM_REQ-1:0]         s_last,
    output logic [NUM_REQ-1:0]         s_ready,
    output logic [INSTR_W-1:0]         m_instr,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [ID_W-1:0]            m_src_id,
    output logic                       busy
);

    localparam int unsigned CNT_W = $clog2(BURST_MAX) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    logic             state_q;
    logic [ID_W-1:0]  owner_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [CNT_W-1:0] beat_cnt_q;

    logic [ID_W-1:0]    winner;
    logic               any_valid;
    logic [ID_W-1:0]    next_ptr;
    logic               accept;
    logic               rel;
    logic [INSTR_W-1:0] owner_instr;

    rr_arbiter_comb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .valid  (s_valid),
        .ptr    (rr_ptr_q),
        .winner (winner),
        .any    (any_valid)
    );

    // Only the owner may push, and only when the output slot frees this cycle.
    always_comb begin
        s_ready = '0;
        if (state_q == StLock && enable && (!m_valid || m_ready)) begin
            s_ready[owner_q] = 1'b1;
        end
    end

    assign owner_instr = s_instr[owner_q*INSTR_W +: INSTR_W];
    assign accept      = (state_q == StLock) & s_valid[owner_q] & s_ready[owner_q];
    assign rel         = accept & (s_last[owner_q] | (beat_cnt_q == LAST_BEAT));
    assign next_ptr    = (owner_q == LAST_ID) ? '0 : owner_q + ID_W'(1);
    assign busy        = (state_q == StLock) | m_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            m_valid    <= 1'b0;
            m_instr    <= '0;
            m_src_id   <= '0;
        end else if (!enable) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            m_valid    <= 1'b0;
            m_instr    <= '0;
            m_src_id   <= '0;
        end else begin
            if (state_q == StIdle) begin
                if (any_valid) begin
                    owner_q    <= winner;
                    beat_cnt_q <= '0;
                    state_q    <= StLock;
                end
            end else if (accept) begin
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                if (rel) begin
                    state_q  <= StIdle;
                    rr_ptr_q <= next_ptr;
                end
            end

            if (accept) begin
                m_instr  <= owner_instr;
                m_src_id <= owner_q;
                m_valid  <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pim_instr_arbiter.sv
// Directed self-checking bench for pim_instr_arbiter (4 requesters, BURST_MAX=8).
module tb_pim_instr_arbiter;

    localparam int NR = 4;
    localparam int IW = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NR*IW-1:0]  s_instr;
    logic [NR-1:0]     s_valid;
    logic [NR-1:0]     s_last;
    logic [NR-1:0]     s_ready;
    logic [IW-1:0]     m_instr;
    logic              m_valid;
    logic              m_ready;
    logic [1:0]        m_src_id;
    logic              busy;

    // Per-requester source queues: bit 64 is the last flag.
    logic [64:0] srcq [NR][$];
    logic [63:0] log_instr [$];
    logic [1:0]  log_src [$];
    int          log_cyc [$];
    logic [NR-1:0] acc;
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    pim_instr_arbiter #(
        .NUM_REQ   (NR),
        .INSTR_W   (IW),
        .BURST_MAX (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .s_instr  (s_instr),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_instr  (m_instr),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_src_id (m_src_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic refresh();
        for (int i = 0; i < NR; i++) begin
            if (srcq[i].size() > 0) begin
                s_valid[i] = 1'b1;
                s_last[i] = srcq[i][0][64];
                s_instr[i*IW +: IW] = srcq[i][0][63:0];
            end else begin
                s_valid[i] = 1'b0;
                s_last[i] = 1'b0;
                s_instr[i*IW +: IW] = '0;
            end
        end
    endtask

    task automatic push(input int r, input logic [63:0] d, input logic l);
        srcq[r].push_back({l, d});
        refresh();
    endtask

    task automatic clear_all();
        for (int i = 0; i < NR; i++) srcq[i].delete();
        log_instr.delete();
        log_src.delete();
        log_cyc.delete();
        refresh();
    endtask

    // Sources: capture accepts on the quiet edge, pop just after the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            acc = s_valid & s_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            end
            refresh();
        end
    end

    // Output monitor: a beat is delivered when valid and ready meet at the edge.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            log_instr.push_back(m_instr);
            log_src.push_back(m_src_id);
            log_cyc.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (log_instr.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b1;
        m_ready = 1'b1;
        clear_all();
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        checks++; if (m_instr !== 64'h0) begin errors++; $display("FAIL rst_m_instr: got %h want 0", m_instr); end
        checks++; if (m_src_id !== 2'd0) begin errors++; $display("FAIL rst_src_id: got %0d want 0", m_src_id); end
        checks++; if (s_ready !== 4'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0000", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        push(2, 64'h77, 1'b1);
        step(2);
        checks++; if (m_valid !== 1'b0 || s_ready !== 4'b0) begin
            errors++; $display("FAIL rst_held: got valid=%b ready=%b want 0/0000", m_valid, s_ready);
        end
    endtask

    task automatic test_single();
        logic [63:0] exp_i [3];
        int c0;
        bit ok;
        exp_i = '{64'hA1, 64'hA2, 64'hA3};
        do_reset();
        push(1, 64'hA1, 1'b0);
        push(1, 64'hA2, 1'b0);
        push(1, 64'hA3, 1'b1);
        c0 = cyc;
        #1;
        checks++; if (s_ready !== 4'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: got ready=%b busy=%b want 0000/0", s_ready, busy);
        end
        wait_log(3, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d beats want 3", log_instr.size()); end
        if (ok) begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (log_instr[k] !== exp_i[k] || log_src[k] !== 2'd1) begin
                    errors++; $display("FAIL single_beat[%0d]: got %h/src%0d want %h/src1", k, log_instr[k], log_src[k], exp_i[k]);
                end
                checks++; if (log_cyc[k] - c0 !== k + 2) begin
                    errors++; $display("FAIL single_lat[%0d]: got %0d want %0d", k, log_cyc[k] - c0, k + 2);
                end
            end
        end
        step(3);
        checks++; if (log_instr.size() !== 3 || busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL single_end: got beats=%0d busy=%b valid=%b want 3/0/0", log_instr.size(), busy, m_valid);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_s [5];
        logic [63:0] exp_i [5];
        int c0;
        bit ok;
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_i = '{64'h10, 64'h11, 64'h12, 64'h13, 64'h14};
        do_reset();
        push(0, 64'h10, 1'b1);
        push(1, 64'h11, 1'b1);
        push(2, 64'h12, 1'b1);
        push(3, 64'h13, 1'b1);
        push(0, 64'h14, 1'b1);
        c0 = cyc;
        wait_log(5, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d beats want 5", log_instr.size()); end
        if (ok) begin
            for (int k = 0; k < 5; k++) begin
                checks++; if (log_src[k] !== exp_s[k] || log_instr[k] !== exp_i[k]) begin
                    errors++; $display("FAIL rr_grant[%0d]: got src%0d/%h want src%0d/%h", k, log_src[k], log_instr[k], exp_s[k], exp_i[k]);
                end
                checks++; if (log_cyc[k] - c0 !== 2 + 2 * k) begin
                    errors++; $display("FAIL rr_timing[%0d]: got %0d want %0d", k, log_cyc[k] - c0, 2 + 2 * k);
                end
            end
        end
    endtask

    task automatic test_burst();
        logic [1:0] exp_s;
        logic [63:0] exp_i;
        int c0;
        bit ok;
        do_reset();
        for (int k = 0; k < 12; k++) push(2, 64'h200 + 64'(k), 1'b0);
        c0 = cyc;
        step(1);
        push(0, 64'h0F, 1'b1);
        wait_log(13, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_timeout: got %0d beats want 13", log_instr.size()); end
        if (ok) begin
            for (int k = 0; k < 13; k++) begin
                exp_s = (k == 8) ? 2'd0 : 2'd2;
                exp_i = (k < 8) ? 64'h200 + 64'(k) : (k == 8) ? 64'h0F : 64'h200 + 64'(k - 1);
                checks++; if (log_src[k] !== exp_s || log_instr[k] !== exp_i) begin
                    errors++; $display("FAIL burst_beat[%0d]: got src%0d/%h want src%0d/%h", k, log_src[k], log_instr[k], exp_s, exp_i);
                end
            end
            checks++; if (log_cyc[0] - c0 !== 2 || log_cyc[7] - c0 !== 9 || log_cyc[8] - c0 !== 11 || log_cyc[9] - c0 !== 13) begin
                errors++; $display("FAIL burst_timing: got %0d,%0d,%0d,%0d want 2,9,11,13", log_cyc[0] - c0, log_cyc[7] - c0, log_cyc[8] - c0, log_cyc[9] - c0);
            end
        end
        step(3);
        checks++; if (busy !== 1'b1 || log_instr.size() !== 13) begin
            errors++; $display("FAIL burst_locked: got busy=%b beats=%0d want 1/13", busy, log_instr.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        m_ready = 1'b0;
        push(3, 64'h55, 1'b0);
        push(3, 64'h66, 1'b1);
        step(2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (m_valid !== 1'b1 || m_instr !== 64'h55 || m_src_id !== 2'd3 || s_ready !== 4'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b %h src%0d rdy=%b want 1 55 src3 0000", k, m_valid, m_instr, m_src_id, s_ready);
            end
        end
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        wait_log(2, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d beats want 2", log_instr.size()); end
        if (ok) begin
            checks++; if (log_instr[0] !== 64'h55 || log_instr[1] !== 64'h66 || log_src[1] !== 2'd3) begin
                errors++; $display("FAIL bp_order: got %h,%h src%0d want 55,66 src3", log_instr[0], log_instr[1], log_src[1]);
            end
        end
        step(3);
        checks++; if (log_instr.size() !== 2 || m_valid !== 1'b0) begin
            errors++; $display("FAIL bp_dup: got beats=%0d valid=%b want 2/0", log_instr.size(), m_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        push(1, 64'h31, 1'b1);
        for (int k = 0; k < 4; k++) push(2, 64'hB1 + 64'(k), k == 3);
        step(5);
        checks++; if (m_instr !== 64'hB2 || m_src_id !== 2'd2) begin
            errors++; $display("FAIL rmid_pre: got %h/src%0d want b2/src2", m_instr, m_src_id);
        end
        rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0 || m_instr !== 64'h0 || m_src_id !== 2'd0 || s_ready !== 4'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_async: got v=%b %h src%0d rdy=%b busy=%b want all 0", m_valid, m_instr, m_src_id, s_ready, busy);
        end
        clear_all();
        step(1);
        rst = 1'b0;
        push(3, 64'hD3, 1'b1);
        push(0, 64'hD0, 1'b1);
        wait_log(2, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout: got %0d beats want 2", log_instr.size()); end
        if (ok) begin
            checks++; if (log_src[0] !== 2'd0 || log_instr[0] !== 64'hD0 || log_src[1] !== 2'd3 || log_instr[1] !== 64'hD3) begin
                errors++; $display("FAIL rmid_ptr: got src%0d/%h,src%0d/%h want src0/d0,src3/d3", log_src[0], log_instr[0], log_src[1], log_instr[1]);
            end
        end
    endtask

    task automatic test_enable();
        logic [1:0] exp_s [5];
        logic [63:0] exp_i [5];
        bit ok;
        exp_s = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd1};
        exp_i = '{64'h80, 64'h91, 64'h90, 64'h92, 64'h93};
        do_reset();
        push(0, 64'h80, 1'b1);
        push(1, 64'h91, 1'b0);
        push(1, 64'h92, 1'b0);
        push(1, 64'h93, 1'b1);
        step(4);
        checks++; if (s_ready !== 4'b0010 || m_instr !== 64'h91) begin
            errors++; $display("FAIL en_pre: got rdy=%b %h want 0010 91", s_ready, m_instr);
        end
        enable = 1'b0;
        #1;
        checks++; if (s_ready !== 4'b0) begin errors++; $display("FAIL en_ready: got %b want 0000", s_ready); end
        step(1);
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || m_instr !== 64'h0 || m_src_id !== 2'd0) begin
            errors++; $display("FAIL en_clear: got v=%b busy=%b %h src%0d want 0/0/0/0", m_valid, busy, m_instr, m_src_id);
        end
        push(0, 64'h90, 1'b1);
        step(1);
        enable = 1'b1;
        wait_log(5, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL en_timeout: got %0d beats want 5", log_instr.size()); end
        if (ok) begin
            for (int k = 0; k < 5; k++) begin
                checks++; if (log_src[k] !== exp_s[k] || log_instr[k] !== exp_i[k]) begin
                    errors++; $display("FAIL en_beat[%0d]: got src%0d/%h want src%0d/%h", k, log_src[k], log_instr[k], exp_s[k], exp_i[k]);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        m_ready = 1'b1;
        s_valid = '0;
        s_last = '0;
        s_instr = '0;
        acc = '0;
        test_reset();
        test_single();
        test_fairness();
        test_burst();
        test_backpressure();
        test_reset_mid();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
